map_tile_store: RTL and testbench

- Tile memory that answers the map display scanner's per-cell tile-type lookups. The scanner presents a grid coordinate and receives a 4-bit tile type.
- Also owns the live 21x21 map state. Game logic writes tile changes through it, e.g. orb eaten → empty.
- Tracks the remaining-orb count and flags level completion.
- On reset, it rebuilds the default maze with an internal init sweep.

---
 rtl/map_tile_store.sv | 137 +++++++++++++
 tb/tb_map_tile_store.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_tile_store.sv
// Live 21x21 tile map for the display scanner, with orb accounting and level-clear pulse.
// Define GHOST_HOUSE_EN to have the init sweep paint the grey ghost-house block.
module map_tile_store #(
  parameter int GRID_SIZE  = 21,
  parameter int CORNER_OFS = 1
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [4:0] rd_x,
  input  logic [4:0] rd_y,
  output logic [3:0] rd_type,
  input  logic       wr_en,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [3:0] wr_type,
  output logic       busy,
  output logic [8:0] orbs_left,
  output logic       level_clear
);

  localparam int         CELLS    = GRID_SIZE * GRID_SIZE;
  localparam int         AW       = $clog2(CELLS);
  localparam logic [4:0] LAST     = 5'(GRID_SIZE - 1);
  localparam logic [4:0] C_LO     = 5'(CORNER_OFS);
  localparam logic [4:0] C_HI     = 5'(GRID_SIZE - 1 - CORNER_OFS);
  localparam logic [8:0] MAX_ORBS = 9'(CELLS);
`ifdef GHOST_HOUSE_EN
  localparam int         HOUSE_CELLS = 15;
`else
  localparam int         HOUSE_CELLS = 0;
`endif
  localparam logic [8:0] INIT_ORBS = 9'((GRID_SIZE - 2) * (GRID_SIZE - 2) - HOUSE_CELLS);

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] x, input logic [4:0] y);
    return AW'(y) * AW'(GRID_SIZE) + AW'(x);
  endfunction

  function automatic logic [3:0] init_code(input logic [4:0] x, input logic [4:0] y);
    logic [3:0] code;
    if (x == 5'd0 || y == 5'd0 || x == LAST || y == LAST) code = 4'd3;
`ifdef GHOST_HOUSE_EN
    else if (x >= 5'd8 && x <= 5'd12 && y >= 5'd9 && y <= 5'd11) code = 4'd4;
`endif
    else if ((x == C_LO || x == C_HI) && (y == C_LO || y == C_HI)) code = 4'd1;
    else code = 4'd2;
    return code;
  endfunction

  function automatic logic is_orb(input logic [3:0] code);
    return (code == 4'd1) || (code == 4'd2);
  endfunction

  state_t     r_state;
  logic [4:0] r_sweep_x, r_sweep_y;
  logic       r_sweep_done;
  logic [3:0] r_rd_type;
  logic       r_busy;
  logic [8:0] r_orbs_left;
  logic       r_level_clear;
  logic [3:0] r_mem [CELLS];

  logic          w_rd_ok, w_wr_ok, w_run_wr, w_init_wr, w_mem_we;
  logic [AW-1:0] w_rd_addr, w_wr_addr, w_mem_addr;
  logic [3:0]    w_rd_data, w_wr_old, w_mem_data;
  logic [8:0]    w_orbs_next;

  assign w_rd_ok    = (rd_x <= LAST) && (rd_y <= LAST);
  assign w_wr_ok    = (wr_x <= LAST) && (wr_y <= LAST);
  assign w_rd_addr  = cell_addr(rd_x, rd_y);
  assign w_wr_addr  = cell_addr(wr_x, wr_y);
  assign w_rd_data  = w_rd_ok ? r_mem[w_rd_addr] : 4'd0;
  assign w_wr_old   = w_wr_ok ? r_mem[w_wr_addr] : 4'd0;
  assign w_run_wr   = (r_state == S_RUN) && wr_en && w_wr_ok;
  assign w_init_wr  = (r_state == S_INIT) && !r_sweep_done;
  assign w_mem_we   = !reset && (w_init_wr || w_run_wr);
  assign w_mem_addr = w_init_wr ? cell_addr(r_sweep_x, r_sweep_y) : w_wr_addr;
  assign w_mem_data = w_init_wr ? init_code(r_sweep_x, r_sweep_y) : wr_type;

  // Orb delta uses the pre-write cell contents; count saturates at both ends.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_orbs_next = r_orbs_left;
    if (w_run_wr) begin
      if (is_orb(w_wr_old) && !is_orb(wr_type) && r_orbs_left != 9'd0)
        w_orbs_next = r_orbs_left - 9'd1;
      else if (!is_orb(w_wr_old) && is_orb(wr_type) && r_orbs_left != MAX_ORBS)
        w_orbs_next = r_orbs_left + 9'd1;
    end
  end

  // NOTE: the tile array has no reset; the init sweep rebuilds it, so it can map onto RAM.
  always_ff @(posedge clock_50) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clock_50) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_state       <= S_INIT;
      r_sweep_x     <= 5'd0;
      r_sweep_y     <= 5'd0;
      r_sweep_done  <= 1'b0;
      r_rd_type     <= 4'd0;
      r_busy        <= 1'b1;
      r_orbs_left   <= 9'd0;
      r_level_clear <= 1'b0;
    end else begin
      r_level_clear <= 1'b0;
      if (r_state == S_INIT) begin
        r_rd_type <= 4'd0;
        if (r_sweep_done) begin
          r_state     <= S_RUN;
          r_busy      <= 1'b0;
          r_orbs_left <= INIT_ORBS;
        end else if (r_sweep_x == LAST) begin
          r_sweep_x <= 5'd0;
          if (r_sweep_y == LAST) r_sweep_done <= 1'b1;
          else                   r_sweep_y    <= r_sweep_y + 5'd1;
        end else begin
          r_sweep_x <= r_sweep_x + 5'd1;
        end
      end else begin
        r_rd_type     <= w_rd_data;
        r_orbs_left   <= w_orbs_next;
        r_level_clear <= (r_orbs_left != 9'd0) && (w_orbs_next == 9'd0);
      end
    end
  end

  assign rd_type     = r_rd_type;
  assign busy        = r_busy;
  assign orbs_left   = r_orbs_left;
  assign level_clear = r_level_clear;

endmodule

// File: tb/tb_map_tile_store.sv
// Scoreboard bench for map_tile_store: reference grid model, queued read expectations.
module tb_map_tile_store;

  localparam int G = 21;
`ifdef GHOST_HOUSE_EN
  localparam int INIT_ORBS = 346;
`else
  localparam int INIT_ORBS = 361;
`endif

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [4:0] rd_x = '0, rd_y = '0, wr_x = '0, wr_y = '0;
  logic [3:0] wr_type = '0;
  logic       wr_en = 1'b0;
  logic [3:0] rd_type;
  logic       busy;
  logic [8:0] orbs_left;
  logic       level_clear;

  map_tile_store dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_type    (rd_type),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_type    (wr_type),
    .busy       (busy),
    .orbs_left  (orbs_left),
    .level_clear(level_clear)
  );

  always #5 clock_50 = ~clock_50;

  int         n_vec = 0;
  int         n_err = 0;
  int         model [G][G];
  int         m_orbs;
  int         lc_count;
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_cell(input int x, input int y);
    if (x == 0 || y == 0 || x == G - 1 || y == G - 1) return 3;
`ifdef GHOST_HOUSE_EN
    if (x >= 8 && x <= 12 && y >= 9 && y <= 11) return 4;
`endif
    if ((x == 1 || x == G - 2) && (y == 1 || y == G - 2)) return 1;
    return 2;
  endfunction

  function automatic bit is_orb(input int c);
    return (c == 1) || (c == 2);
  endfunction

  task automatic model_init();
    for (int y = 0; y < G; y++)
      for (int x = 0; x < G; x++)
        model[y][x] = ref_cell(x, y);
    m_orbs = INIT_ORBS;
  endtask

  task automatic step();
    @(posedge clock_50);
    @(negedge clock_50);
  endtask

  // One RUN cycle: read address plus optional write, checked against the model.
  task automatic run_cycle(input int rx, input int ry, input bit we,
                           input int wx, input int wy, input int wt);
    int prev;
    int old;
    rd_x    = 5'(rx);
    rd_y    = 5'(ry);
    wr_en   = we;
    wr_x    = 5'(wx);
    wr_y    = 5'(wy);
    wr_type = 4'(wt);
    if (rx < G && ry < G) exp_q.push_back(4'(model[ry][rx]));
    else                  exp_q.push_back(4'd0);
    prev = m_orbs;
    if (we && wx < G && wy < G) begin
      old = model[wy][wx];
      if (is_orb(old) && !is_orb(wt) && m_orbs > 0)        m_orbs--;
      else if (!is_orb(old) && is_orb(wt) && m_orbs < G*G) m_orbs++;
      model[wy][wx] = wt;
    end
    step();
    wr_en = 1'b0;
    if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
    else check($sformatf("rd_type(%0d,%0d)", rx, ry), rd_type, exp_q.pop_front());
    check("orbs_left", orbs_left, m_orbs);
    check("level_clear", level_clear, (prev != 0 && m_orbs == 0));
    if (level_clear) lc_count++;
  endtask

  // Called right after reset is released; runs the sweep to its end.
  task automatic sweep_check();
    int cnt;
    bit lc_seen;
    bit rd_bad;
    cnt = 0; lc_seen = 0; rd_bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (level_clear) lc_seen = 1;
      if (rd_type !== 4'd0) rd_bad = 1;
      if (!busy) break;
      cnt++;
    end
    check("busy_cycles", cnt, 441);
    check("init_orbs", orbs_left, INIT_ORBS);
    check("init_level_clear", lc_seen, 0);
    check("init_rd_zero", rd_bad, 0);
  endtask

  task automatic read_grid();
    for (int y = 0; y < G; y++)
      for (int x = 0; x < G; x++)
        run_cycle(x, y, 0, 0, 0, 0);
  endtask

  initial begin
    bit bad;

    // Reset cycle outputs
    reset = 1'b1;
    rd_x  = 5'd1; rd_y = 5'd1;
    step();
    check("rst_rd_type", rd_type, 0);
    check("rst_busy", busy, 1);
    check("rst_orbs", orbs_left, 0);
    check("rst_level_clear", level_clear, 0);
    reset = 1'b0;
    sweep_check();
    model_init();

    // Pipelined reads, then full-grid and out-of-range reads
    run_cycle(0, 5, 0, 0, 0, 0);
    run_cycle(1, 1, 0, 0, 0, 0);
    run_cycle(5, 5, 0, 0, 0, 0);
    run_cycle(20, 20, 0, 0, 0, 0);
    run_cycle(21, 3, 0, 0, 0, 0);
    run_cycle(3, 21, 0, 0, 0, 0);
    run_cycle(31, 31, 0, 0, 0, 0);
    read_grid();

    // Orb to empty, empty to empty, empty to orb
    run_cycle(5, 5, 1, 5, 5, 0);
    check("w55_clear", orbs_left, INIT_ORBS - 1);
    run_cycle(5, 5, 1, 5, 5, 0);
    check("w55_again", orbs_left, INIT_ORBS - 1);
    run_cycle(5, 5, 1, 5, 5, 2);
    check("w55_restore", orbs_left, INIT_ORBS);

    // Same-edge read and write: old value first, new value next read
    run_cycle(1, 1, 1, 1, 1, 0);
    run_cycle(1, 1, 0, 0, 0, 0);
    check("rbw_orbs", orbs_left, INIT_ORBS - 1);

    // Out-of-range writes ignored; non-orb codes
    run_cycle(0, 0, 1, 21, 3, 0);
    run_cycle(0, 0, 1, 3, 21, 2);
    run_cycle(0, 0, 1, 0, 0, 4);
    run_cycle(0, 0, 1, 2, 2, 9);
    run_cycle(2, 2, 1, 0, 1, 15);
    run_cycle(0, 1, 0, 0, 0, 0);

    // Clear every remaining orb: exactly one level_clear pulse
    lc_count = 0;
    for (int y = 0; y < G; y++)
      for (int x = 0; x < G; x++)
        if (is_orb(model[y][x])) run_cycle(x, y, 1, x, y, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0);
    check("clear_orbs", orbs_left, 0);
    check("lc_pulses", lc_count, 1);

    // Restore an orb, orb-to-orb write, clear again: re-armed pulse
    run_cycle(7, 7, 1, 7, 7, 2);
    check("w77_orbs", orbs_left, 1);
    run_cycle(7, 7, 1, 7, 7, 1);
    run_cycle(7, 7, 1, 7, 7, 0);
    run_cycle(7, 7, 0, 0, 0, 0);
    check("lc_rearm", lc_count, 2);

    // Reset mid-sweep at cell 200, with out-of-range traffic
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_x = 5'd21; rd_y = 5'd3;
    wr_x = 5'd21; wr_y = 5'd3; wr_type = 4'd0; wr_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rd_type !== 4'd0 || busy !== 1'b1 || orbs_left !== 9'd0) bad = 1;
    end
    check("mid_sweep_quiet", bad, 0);
    reset = 1'b1;
    step();
    check("mid_rst_busy", busy, 1);
    check("mid_rst_orbs", orbs_left, 0);
    reset = 1'b0;
    // In-range write held through the sweep must be ignored
    wr_x = 5'd3; wr_y = 5'd3; wr_type = 4'd0; wr_en = 1'b1;
    rd_x = 5'd3; rd_y = 5'd3;
    sweep_check();
    wr_en = 1'b0;
    model_init();
    read_grid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
